// File: rtl/jt1942_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters.
// Each slot keeps a one-word cache (data + address tag), so repeated reads of
// the same address never reach the SDRAM. Refresh is allowed while idle.
module jt1942_sdram_arb #(
    parameter int SLOTS = 5,
    parameter int AW    = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*32-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [31:0]         data_read,
    output logic                refresh_en
);

    localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } state_t;

    state_t           state_q, state_d;
    logic             arm_q, arm_d;         // grant latched in IDLE, request goes out next cycle
    logic [GW-1:0]    gnt_q, gnt_d;
    logic [GW-1:0]    last_q, last_d;
    logic             req_q, req_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             refresh_q, refresh_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [AW-1:0]    tag_q  [SLOTS];
    logic [AW-1:0]    tag_d  [SLOTS];
    logic [31:0]      dout_q [SLOTS];
    logic [31:0]      dout_d [SLOTS];

    logic [SLOTS-1:0] hit, pend;
    logic [GW-1:0]    pick, scan_slot;
    logic             pick_vld;
    int               scan_idx;
    logic             abort, done;

    assign abort = downloading | loop_rst;

    // Per-slot cache lookup: a hit needs a valid tag matching the live address.
    always_comb begin
        // NOTE: every signal driven here gets a default before any condition,
        // otherwise synthesis infers a latch to hold the missing cases.
        hit       = '0;
        slot_ok   = '0;
        pend      = '0;
        slot_dout = '0;
        for (int i = 0; i < SLOTS; i++) begin
            hit[i]                = valid_q[i] && (tag_q[i] == slot_addr[i*AW +: AW]);
            slot_ok[i]            = slot_cs[i] & hit[i];
            pend[i]               = slot_cs[i] & ~hit[i];
            slot_dout[i*32 +: 32] = dout_q[i];
        end
    end

    // Round-robin pick: first pending slot scanning upward from last+1.
    always_comb begin
        pick      = last_q;
        pick_vld  = 1'b0;
        scan_idx  = 0;
        scan_slot = '0;
        for (int k = 1; k <= SLOTS; k++) begin
            scan_idx  = (int'(last_q) + k) % SLOTS;
            scan_slot = GW'(scan_idx);
            if (!pick_vld && pend[scan_slot]) begin
                pick     = scan_slot;
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state logic: transaction sequencing and cache fill.
    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        dout_d    = dout_q;
        done      = 1'b0;
        refresh_d = (state_q == IDLE) && !(|pend) && !downloading;

        if (abort) begin
            // Cached data is left in place but can no longer hit.
            state_d = IDLE;
            arm_d   = 1'b0;
            req_d   = 1'b0;
            valid_d = '0;
            last_d  = GW'(SLOTS - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm_q) begin
                        req_d   = 1'b1;
                        arm_d   = 1'b0;
                        state_d = WAIT_ACK;
                    end else if (pick_vld) begin
                        gnt_d  = pick;
                        addr_d = slot_addr[int'(pick)*AW +: AW];
                        arm_d  = 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        req_d = 1'b0;
                        if (data_rdy) begin
                            // Ack and data together: finish in one step.
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (data_rdy) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Data is filed under the latched address, even if the requester
            // has moved on, so the tag always describes the stored word.
            if (done) begin
                dout_d[gnt_q]  = data_read;
                tag_d[gnt_q]   = addr_q;
                valid_d[gnt_q] = 1'b1;
                last_d         = gnt_q;
            end
        end
    end

    // State and cache registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q   <= IDLE;
            arm_q     <= 1'b0;
            gnt_q     <= '0;
            last_q    <= GW'(SLOTS - 1);
            req_q     <= 1'b0;
            addr_q    <= '0;
            refresh_q <= 1'b0;
            valid_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                // NOTE: the data words are visible on slot_dout, so they are
                // cleared on reset instead of being left as an unreset RAM.
                dout_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            refresh_q <= refresh_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            dout_q    <= dout_d;
        end
    end

    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jt1942_sdram_arb.sv
// Self-checking bench for jt1942_sdram_arb: directed scenarios plus randomized
// rounds checked against a transaction-level cache / round-robin model.
module tb_jt1942_sdram_arb;

    localparam int SLOTS = 5;
    localparam int AW    = 22;

    logic                clk;
    logic                rst_n;
    logic                downloading;
    logic                loop_rst;
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [31:0]         data_read;
    logic                refresh_en;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one cached word per slot and the last served slot.
    bit          mvalid [SLOTS];
    logic [AW-1:0] mtag [SLOTS];
    int          mlast;

    jt1942_sdram_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .downloading(downloading),
        .loop_rst   (loop_rst),
        .slot_cs    (slot_cs),
        .slot_addr  (slot_addr),
        .slot_ok    (slot_ok),
        .slot_dout  (slot_dout),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_rdy   (data_rdy),
        .data_read  (data_read),
        .refresh_en (refresh_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) + 32'h1357_2468;
    endfunction

    function automatic logic [AW-1:0] get_addr(input int i);
        return slot_addr[i*AW +: AW];
    endfunction

    function automatic logic [31:0] get_dout(input int i);
        return slot_dout[i*32 +: 32];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [SLOTS-1:0] model_pend();
        logic [SLOTS-1:0] p;
        p = '0;
        for (int i = 0; i < SLOTS; i++)
            p[i] = slot_cs[i] && !(mvalid[i] && mtag[i] == get_addr(i));
        return p;
    endfunction

    function automatic int next_grant(input logic [SLOTS-1:0] p, input int last);
        for (int k = 1; k <= SLOTS; k++)
            if (p[(last + k) % SLOTS]) return (last + k) % SLOTS;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
        mlast = SLOTS - 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
        slot_cs = '0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Acts as the SDRAM controller for one transaction. Entered and left on a
    // negedge; returns on the negedge after the completing edge.
    task automatic serve(input int ack_dly, input int rdy_dly, input bit fixed,
                         input logic [31:0] fdata, output logic [AW-1:0] got, output bit seen);
        int n;
        logic [31:0] d;
        seen = 1'b0; got = '0; n = 0;
        while (sdram_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (sdram_req !== 1'b1) begin
            n_fail++;
            $display("FAIL req_wait: sdram_req=%b after %0d cycles, want 1", sdram_req, n);
            return;
        end
        seen = 1'b1;
        got  = sdram_addr;
        d    = fixed ? fdata : mem_word(got);
        for (int k = 0; k < ack_dly; k++) begin
            if (k == 0) begin data_rdy = 1'b1; data_read = ~d; end   // stray data in WAIT_ACK
            @(negedge clk);
            data_rdy = 1'b0;
            n_tests++;
            if (sdram_req !== 1'b1 || sdram_addr !== got || refresh_en !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_ack: req=%b addr=%h refresh=%b, want req=1 addr=%h refresh=0",
                         sdram_req, sdram_addr, refresh_en, got);
            end
        end
        sdram_ack = 1'b1;
        if (rdy_dly == 0) begin data_rdy = 1'b1; data_read = d; end
        @(negedge clk);
        sdram_ack = 1'b0; data_rdy = 1'b0;
        n_tests++;
        if (sdram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_drop: sdram_req=%b after ack, want 0", sdram_req);
        end
        if (rdy_dly > 0) begin
            for (int k = 1; k < rdy_dly; k++) begin
                sdram_ack = 1'b1;                                   // stray ack in WAIT_RDY
                @(negedge clk);
                sdram_ack = 1'b0;
                n_tests++;
                if (sdram_req !== 1'b0 || refresh_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_rdy: req=%b refresh=%b, want 0 0", sdram_req, refresh_en);
                end
            end
            data_rdy = 1'b1; data_read = d;
            @(negedge clk);
            data_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        slot_cs = '1;
        @(negedge clk);
        n_tests++;
        if (sdram_req !== 1'b0 || sdram_addr !== '0 || refresh_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: req=%b addr=%h refresh=%b, want 0 0 0", sdram_req, sdram_addr, refresh_en);
        end
        n_tests++;
        if (slot_ok !== '0 || slot_dout !== '0) begin
            n_fail++;
            $display("FAIL reset_slots: ok=%b dout=%h, want 0 0", slot_ok, slot_dout);
        end
        slot_cs = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_first_miss();
        logic [AW-1:0] got;
        bit seen;
        int bad;
        do_reset();
        slot_cs[2] = 1'b1;
        set_addr(2, 22'h00100);
        @(negedge clk);
        n_tests++;
        if (sdram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_lat1: sdram_req=%b one cycle after cs, want 0", sdram_req);
        end
        @(negedge clk);
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h00100) begin
            n_fail++;
            $display("FAIL miss_lat2: req=%b addr=%h two cycles after cs, want 1 00100", sdram_req, sdram_addr);
        end
        serve(0, 1, 1'b1, 32'hDEAD_BEEF, got, seen);
        n_tests++;
        if (slot_ok[2] !== 1'b1 || get_dout(2) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL first_fill: ok2=%b dout2=%h, want 1 deadbeef", slot_ok[2], get_dout(2));
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (sdram_req !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL repeat_hit: sdram_req high %0d cycles on a cached address, want 0", bad);
        end
        n_tests++;
        if (refresh_en !== 1'b1) begin
            n_fail++;
            $display("FAIL refresh_after_hit: refresh_en=%b, want 1", refresh_en);
        end
    endtask

    task automatic test_fairness();
        logic [AW-1:0] got;
        logic [AW-1:0] exp_seq [5];
        bit seen;
        do_reset();
        exp_seq = '{22'h01000, 22'h02000, 22'h03000, 22'h01004, 22'h01008};
        slot_cs = 5'b01011;
        set_addr(0, 22'h01000); set_addr(1, 22'h02000); set_addr(3, 22'h03000);
        for (int t = 0; t < 5; t++) begin
            serve(t % 3, (t + 1) % 3, 1'b0, '0, got, seen);
            if (!seen) break;
            n_tests++;
            if (got !== exp_seq[t]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: sdram_addr=%h, want %h", t, got, exp_seq[t]);
            end
            if (t == 0) set_addr(0, 22'h01004);
            if (t == 3) set_addr(0, 22'h01008);
        end
    endtask

    task automatic test_addr_change();
        logic [AW-1:0] got;
        bit seen;
        int n;
        do_reset();
        slot_cs[1] = 1'b1;
        set_addr(1, 22'h00200);
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h00200) begin
            n_fail++;
            $display("FAIL chg_req: req=%b addr=%h, want 1 00200", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        set_addr(1, 22'h00204);
        data_rdy = 1'b1; data_read = 32'h1234_5678;
        @(negedge clk);
        data_rdy = 1'b0;
        n_tests++;
        if (slot_ok[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_ok: slot_ok[1]=%b with moved address, want 0", slot_ok[1]);
        end
        set_addr(1, 22'h00200);
        #1;
        n_tests++;
        if (slot_ok[1] !== 1'b1 || get_dout(1) !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL chg_tag: ok1=%b dout1=%h under old address, want 1 12345678", slot_ok[1], get_dout(1));
        end
        set_addr(1, 22'h00204);
        serve(1, 2, 1'b0, '0, got, seen);
        n_tests++;
        if (got !== 22'h00204 || slot_ok[1] !== 1'b1 || get_dout(1) !== mem_word(22'h00204)) begin
            n_fail++;
            $display("FAIL chg_refetch: addr=%h ok1=%b dout1=%h, want 00204 1 %h",
                     got, slot_ok[1], get_dout(1), mem_word(22'h00204));
        end
    endtask

    task automatic test_download();
        logic [AW-1:0] got;
        logic [AW-1:0] exp_seq [3];
        bit seen;
        int n;
        do_reset();
        exp_seq = '{22'h00500, 22'h00600, 22'h00700};
        slot_cs[2] = 1'b1;
        set_addr(2, 22'h00700);
        serve(0, 2, 1'b0, '0, got, seen);
        slot_cs[0] = 1'b1; slot_cs[1] = 1'b1;
        set_addr(0, 22'h00500); set_addr(1, 22'h00600);
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h00500) begin
            n_fail++;
            $display("FAIL dl_req: req=%b addr=%h, want 1 00500", sdram_req, sdram_addr);
        end
        downloading = 1'b1;
        @(negedge clk);
        downloading = 1'b0;
        n_tests++;
        if (sdram_req !== 1'b0 || slot_ok !== '0 || get_dout(2) !== mem_word(22'h00700)) begin
            n_fail++;
            $display("FAIL dl_abort: req=%b ok=%b dout2=%h, want 0 0 %h",
                     sdram_req, slot_ok, get_dout(2), mem_word(22'h00700));
        end
        data_rdy = 1'b1; data_read = 32'hBAD0_BAD0;
        @(negedge clk);
        data_rdy = 1'b0;
        n_tests++;
        if (slot_ok !== '0 || get_dout(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL dl_stray_rdy: ok=%b dout0=%h, want 0 0", slot_ok, get_dout(0));
        end
        for (int t = 0; t < 3; t++) begin
            serve(1, 1, 1'b0, '0, got, seen);
            if (!seen) break;
            n_tests++;
            if (got !== exp_seq[t]) begin
                n_fail++;
                $display("FAIL dl_reorder[%0d]: sdram_addr=%h, want %h", t, got, exp_seq[t]);
            end
        end
        n_tests++;
        if (slot_ok !== 5'b00111) begin
            n_fail++;
            $display("FAIL dl_refill: slot_ok=%b, want 00111", slot_ok);
        end
        loop_rst = 1'b1;
        @(negedge clk);
        loop_rst = 1'b0;
        n_tests++;
        if (slot_ok !== '0 || sdram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL loop_rst: ok=%b req=%b, want 0 0", slot_ok, sdram_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] got;
        bit seen;
        int n;
        do_reset();
        slot_cs = 5'b10001;
        set_addr(0, 22'h00800); set_addr(4, 22'h00900);
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h00800) begin
            n_fail++;
            $display("FAIL b2b_req: req=%b addr=%h, want 1 00800", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'hA5A5_0001;
        @(negedge clk);
        sdram_ack = 1'b0; data_rdy = 1'b0;
        n_tests++;
        if (sdram_req !== 1'b0 || slot_ok[0] !== 1'b1 || get_dout(0) !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL b2b_done: req=%b ok0=%b dout0=%h, want 0 1 a5a50001",
                     sdram_req, slot_ok[0], get_dout(0));
        end
        @(negedge clk);
        n_tests++;
        if (sdram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: sdram_req=%b one cycle after completion, want 0", sdram_req);
        end
        @(negedge clk);
        n_tests++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h00900) begin
            n_fail++;
            $display("FAIL b2b_next: req=%b addr=%h two cycles after completion, want 1 00900",
                     sdram_req, sdram_addr);
        end
        serve(1, 1, 1'b0, '0, got, seen);
        n_tests++;
        if (slot_ok !== 5'b10001) begin
            n_fail++;
            $display("FAIL b2b_both: slot_ok=%b, want 10001", slot_ok);
        end
    endtask

    task automatic test_refresh();
        logic [AW-1:0] got;
        bit seen;
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (refresh_en !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL refresh_idle: refresh_en low %0d of 10 idle cycles, want 0", bad);
        end
        slot_cs[3] = 1'b1;
        set_addr(3, 22'h00A00);
        @(negedge clk);
        n_tests++;
        if (refresh_en !== 1'b0) begin
            n_fail++;
            $display("FAIL refresh_miss: refresh_en=%b the cycle after a miss, want 0", refresh_en);
        end
        serve(2, 2, 1'b0, '0, got, seen);
        repeat (2) @(negedge clk);
        n_tests++;
        if (refresh_en !== 1'b1 || slot_ok[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL refresh_back: refresh=%b ok3=%b, want 1 1", refresh_en, slot_ok[3]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] got;
        logic [SLOTS-1:0] mp;
        bit seen;
        int exp;
        do_reset();
        for (int r = 0; r < 40; r++) begin
            slot_cs = SLOTS'($urandom_range(0, (1 << SLOTS) - 1));
            for (int i = 0; i < SLOTS; i++)
                set_addr(i, AW'((i * 7 + $urandom_range(0, 3)) * 32'h1235));
            for (int t = 0; t < 2 * SLOTS; t++) begin
                mp = model_pend();
                if (mp == '0) break;
                exp = next_grant(mp, mlast);
                serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, '0, got, seen);
                if (!seen) break;
                n_tests++;
                if (got !== get_addr(exp)) begin
                    n_fail++;
                    $display("FAIL rnd_grant r%0d: sdram_addr=%h, want slot %0d addr %h",
                             r, got, exp, get_addr(exp));
                end
                mvalid[exp] = 1'b1;
                mtag[exp]   = get_addr(exp);
                mlast       = exp;
            end
            sdram_ack = 1'b1; data_rdy = 1'b1; data_read = $urandom;
            @(negedge clk);
            sdram_ack = 1'b0; data_rdy = 1'b0;
            repeat (2) @(negedge clk);
            n_tests++;
            if (slot_ok !== slot_cs || sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_settle r%0d: ok=%b req=%b refresh=%b, want %b 0 1",
                         r, slot_ok, sdram_req, refresh_en, slot_cs);
            end
            for (int i = 0; i < SLOTS; i++) begin
                if (slot_cs[i]) begin
                    n_tests++;
                    if (get_dout(i) !== mem_word(get_addr(i))) begin
                        n_fail++;
                        $display("FAIL rnd_data r%0d slot %0d: dout=%h, want %h",
                                 r, i, get_dout(i), mem_word(get_addr(i)));
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
        slot_cs = '0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        model_reset();
        test_reset();
        test_first_miss();
        test_fairness();
        test_addr_change();
        test_download();
        test_back_to_back();
        test_refresh();
        test_random();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
